// File: rtl/dl_pkg.sv
// Shared types and defaults for the serial delay-line reader.
package dl_pkg;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } dl_state_t;

  localparam int DL_DEPTH_DEF  = 28;
  localparam int WORD_BITS_DEF = 28;

endpackage

// File: rtl/dl_shift.sv
// DEPTH-stage serial store; din enters the head, tail is the oldest bit.
module dl_shift #(
  parameter int DEPTH = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift,
  input  logic din,
  output logic tail
);

  logic [DEPTH-1:0] line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
    end else if (shift) begin
      line <= {line[DEPTH-2:0], din};
    end
  end

  assign tail = line[DEPTH-1];

endmodule

// File: rtl/delay_line_reader.sv
// Delay-line reader: framing FSM, bit counter and serial read-out.
// Optional odd-parity frame check enabled by defining DL_PARITY_EN.
module delay_line_reader
  import dl_pkg::*;
#(
  parameter int DEPTH     = DL_DEPTH_DEF,
  parameter int WORD_BITS = WORD_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         bit_stb,
  input  logic                         word_sync,
  input  logic                         wr_en,
  input  logic                         DL44,
  output logic                         ACC0,
  output logic                         ACC0N,
  output logic [$clog2(WORD_BITS)-1:0] bit_cnt,
  output logic                         word_done,
  output logic                         par_err
);

  localparam int CW = $clog2(WORD_BITS);
  localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

  dl_state_t state, state_nxt;
  logic      adv;
  logic      last;
  logic      tail;
  logic      din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    unique case (state)
      SYNC_WAIT: begin
        if (bit_stb && word_sync) begin
          state_nxt = RUN;
          adv       = 1'b1;
        end
      end
      RUN: adv = bit_stb;
    endcase
  end

  assign last = (bit_cnt == LAST);
  assign din  = wr_en ? DL44 : tail;

  dl_shift #(
    .DEPTH(DEPTH)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (adv),
    .din   (din),
    .tail  (tail)
  );

  // A sync landing on the last bit is just the normal wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ACC0      <= 1'b0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= adv && last;
      if (adv) begin
        ACC0 <= tail;
        if (last || word_sync) bit_cnt <= '0;
        else                   bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  assign ACC0N = ~ACC0;

`ifdef DL_PARITY_EN
  logic par_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
      par_err <= 1'b0;
    end else if (adv) begin
      if (last || word_sync) par_acc <= 1'b0;
      else                   par_acc <= par_acc ^ tail;
      if (last && !(par_acc ^ tail)) par_err <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_delay_line_reader.sv
// Bench for delay_line_reader: vector table, directed frames, random gaps.
// Expected values come from a queue-based model of the delay line.
module tb_delay_line_reader;

  localparam int DEPTH = 28;
  localparam int WB    = 28;
  localparam int CW    = $clog2(WB);
  localparam int NRND  = 100;
`ifdef DL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_stb, word_sync, wr_en, DL44;
  logic          ACC0, ACC0N, word_done, par_err;
  logic [CW-1:0] bit_cnt;

  int vectors = 0;
  int miscompares = 0;

  bit m_run, m_acc, m_wd, m_perr;
  bit m_q[$];
  int m_cnt, m_ones;

  bit rec_cur[$], rec_a[$], rec_b[$];
  bit sw[NRND], sd[NRND];

  typedef struct {
    bit stb, sync, wr, d;
    bit e_acc;
    int e_cnt;
    bit e_wd;
  } tv_t;
  tv_t tbl[8];

  always #5 clk = ~clk;

  delay_line_reader #(
    .DEPTH(DEPTH),
    .WORD_BITS(WB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_stb   (bit_stb),
    .word_sync (word_sync),
    .wr_en     (wr_en),
    .DL44      (DL44),
    .ACC0      (ACC0),
    .ACC0N     (ACC0N),
    .bit_cnt   (bit_cnt),
    .word_done (word_done),
    .par_err   (par_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_acc = 0; m_wd = 0; m_perr = 0;
    m_cnt = 0; m_ones = 0;
    m_q.delete();
    repeat (DEPTH) m_q.push_back(1'b0);
  endtask

  // One strobe: the oldest bit is read out, the new one appended.
  task automatic m_step(input bit stb, sync, wr, d);
    bit t;
    m_wd = 0;
    if (stb && (m_run || sync)) begin
      m_run = 1;
      t = m_q.pop_front();
      m_acc = t;
      m_q.push_back(wr ? d : t);
      if (m_cnt == WB - 1) begin
        m_ones += int'(t);
        if (PAR && (m_ones % 2 == 0)) m_perr = 1;
        m_ones = 0;
        m_cnt = 0;
        m_wd = 1;
      end else if (sync) begin
        m_ones = 0;
        m_cnt = 0;
      end else begin
        m_ones += int'(t);
        m_cnt++;
      end
    end
  endtask

  task automatic chk_model(input string nm);
    chk(nm, 32'({ACC0, ACC0N, word_done, par_err, bit_cnt}),
        32'({m_acc, ~m_acc, m_wd, m_perr, CW'(m_cnt)}));
  endtask

  task automatic step(input bit stb, sync, wr, d);
    @(negedge clk);
    bit_stb = stb; word_sync = sync; wr_en = wr; DL44 = d;
    @(posedge clk);
    m_step(stb, sync, wr, d);
    #1;
    chk_model("step");
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk_model("async_rst");
    @(negedge clk);
    bit_stb = 0; word_sync = 0;
    rst_n = 1'b1;
  endtask

  task automatic adv_to(input int n);
    int guard = 0;
    while (m_cnt != n && guard < 2 * WB) begin
      step(1, 0, 0, 0);
      guard++;
    end
    chk("adv_to", 32'(bit_cnt), 32'(n));
  endtask

  task automatic run_stream(input bit gaps);
    do_reset();
    rec_cur.delete();
    for (int i = 0; i < NRND; i++) begin
      if (gaps)
        repeat ($urandom_range(0, 5)) step(0, 0, 1'($urandom), 1'($urandom));
      step(1, i == 0, sw[i], sd[i]);
      rec_cur.push_back(ACC0);
    end
  endtask

  // Parity frame: data is fully loaded before the resync, then read back.
  task automatic par_frame(input logic [27:0] p, input bit exp_err);
    do_reset();
    step(1, 1, 1, p[27]);
    for (int i = 1; i < 27; i++) step(1, 0, 1, p[27-i]);
    step(1, 1, 1, p[0]);
    for (int i = 0; i < 28; i++) begin
      step(1, 0, 0, 0);
      chk("par_data", 32'(ACC0), 32'(p[27-i]));
    end
    chk("par_wd", 32'(word_done), 32'd1);
    chk("par_err1", 32'(par_err), 32'(exp_err));
    repeat (28) step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("par_err2", 32'(par_err), 32'(exp_err));
  endtask

  initial begin
    logic [27:0] pat;
    rst_n = 1'b0; bit_stb = 0; word_sync = 0; wr_en = 0; DL44 = 0;
    m_reset();
    #1;
    chk_model("reset");
    chk("reset_raw", 32'({ACC0, ACC0N, bit_cnt, word_done, par_err}),
        32'({1'b0, 1'b1, CW'(0), 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{0, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 1, 0, 0, 0};
    tbl[2] = '{1, 1, 1, 1, 0, 0, 0};
    tbl[3] = '{1, 0, 1, 1, 0, 1, 0};
    tbl[4] = '{0, 0, 1, 0, 0, 1, 0};
    tbl[5] = '{1, 0, 0, 0, 0, 2, 0};
    tbl[6] = '{1, 1, 0, 0, 0, 0, 0};
    tbl[7] = '{1, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].stb, tbl[i].sync, tbl[i].wr, tbl[i].d);
      chk("tbl", 32'({ACC0, bit_cnt, word_done}),
          32'({tbl[i].e_acc, CW'(tbl[i].e_cnt), tbl[i].e_wd}));
    end

    do_reset();
    step(1, 1, 0, 0);
    for (int i = 1; i <= 28; i++) step(1, 0, 1, 1'(i % 2));
    chk("wd_28", 32'(word_done), 32'd1);
    for (int i = 1; i <= 28; i++) begin
      step(1, 0, 0, 0);
      chk("alt_read", 32'(ACC0), 32'(i % 2));
    end
    chk("wd_56", 32'(word_done), 32'd1);

    do_reset();
    pat = 28'h5A5A5A5;
    step(1, 1, 0, 0);
    for (int i = 0; i < 28; i++) step(1, 0, 1, pat[27-i]);
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 28; i++) begin
        step(1, 0, 0, 0);
        chk("recirc", 32'(ACC0), 32'(pat[27-i]));
      end

    adv_to(10);
    step(1, 1, 0, 0);
    chk("resync", 32'({bit_cnt, word_done}), 32'({CW'(0), 1'b0}));
    repeat (40) step(1, 0, 0, 0);
    adv_to(WB - 1);
    step(1, 1, 0, 0);
    chk("sync_wrap", 32'({bit_cnt, word_done}), 32'({CW'(0), 1'b1}));
    step(1, 0, 0, 0);
    chk("after_wrap", 32'({bit_cnt, word_done}), 32'({CW'(1), 1'b0}));

    adv_to(15);
    do_reset();
    chk("mid_rst", 32'({ACC0, ACC0N, bit_cnt}), 32'({1'b0, 1'b1, CW'(0)}));
    repeat (5) step(1, 0, 1, 1);
    chk("no_sync", 32'({ACC0, bit_cnt}), 32'({1'b0, CW'(0)}));

    for (int i = 0; i < NRND; i++) begin
      sw[i] = 1'($urandom);
      sd[i] = 1'($urandom);
    end
    run_stream(1'b0);
    rec_a = rec_cur;
    run_stream(1'b1);
    rec_b = rec_cur;
    for (int i = 0; i < NRND; i++)
      chk("gap_stream", 32'(rec_b[i]), 32'(rec_a[i]));

    par_frame(28'h0000007, 1'b0);
    par_frame(28'h0000003, PAR);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
